// File: rtl/noc_pkg.sv
// Shared flit-format definitions for the NoC endpoint: flit width and the
// position of the destination address in the flit header.
package noc_pkg;

    localparam int FLIT_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int ADDR_MSB = 31;
    localparam int ADDR_LSB = 24;

    function automatic logic [ADDR_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
        return flit[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/endpoint_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module endpoint_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [Width-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [Width-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int AW = $clog2(Depth);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [Width-1:0] r_mem [Depth];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_valid && !w_full;
    assign w_pop   = !w_empty && i_ready;

    // Both handshake outputs come straight from registered pointer state.
    assign o_ready = !w_full;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/noc_endpoint_if.sv
// PE-side network interface: packs PE payloads into addressed flits towards the
// switch, filters and unpacks flits from the switch, and keeps status counters.
module noc_endpoint_if
    import noc_pkg::*;
#(
    parameter int                DataWidth = 32,
    parameter logic [ADDR_W-1:0] MyAddr    = 8'h00,
    parameter int                TxDepth   = 4,
    parameter int                RxDepth   = 4,
    parameter int                CntWidth  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [DataWidth-ADDR_W-1:0] i_pe_payload,
    input  logic [ADDR_W-1:0]           i_pe_dest,
    input  logic                        i_pe_valid,
    output logic                        o_pe_ready,
    output logic [DataWidth-1:0]        o_data,
    output logic                        o_data_valid,
    input  logic                        i_data_ready,
    input  logic [DataWidth-1:0]        i_data,
    input  logic                        i_data_valid,
    output logic                        o_data_ready,
    output logic [DataWidth-ADDR_W-1:0] o_pe_payload,
    output logic                        o_pe_valid,
    input  logic                        i_pe_ready,
    output logic [CntWidth-1:0]         o_tx_count,
    output logic [CntWidth-1:0]         o_rx_count,
    output logic [CntWidth-1:0]         o_drop_count
);

    localparam int PW = DataWidth - ADDR_W;

    logic [DataWidth-1:0] w_tx_flit;
    logic [ADDR_W-1:0]    w_rx_dest;
    logic                 w_rx_hit;
    logic                 w_tx_pop;
    logic                 w_rx_pop;
    logic                 w_rx_drop;

    logic [CntWidth-1:0]  r_tx_count;
    logic [CntWidth-1:0]  r_rx_count;
    logic [CntWidth-1:0]  r_drop_count;

    assign w_tx_flit = {i_pe_dest, i_pe_payload};
    assign w_rx_dest = i_data[DataWidth-1 -: ADDR_W];
    assign w_rx_hit  = (w_rx_dest == MyAddr);

    endpoint_fifo #(
        .Width (DataWidth),
        .Depth (TxDepth)
    ) u_tx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_data    (w_tx_flit),
        .i_valid   (i_pe_valid),
        .o_ready   (o_pe_ready),
        .o_data    (o_data),
        .o_valid   (o_data_valid),
        .i_ready   (i_data_ready)
    );

    // Misaddressed flits are still accepted from the switch so they cannot block
    // the port; they simply never enter the RX FIFO.
    endpoint_fifo #(
        .Width (PW),
        .Depth (RxDepth)
    ) u_rx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_data    (i_data[PW-1:0]),
        .i_valid   (i_data_valid && w_rx_hit),
        .o_ready   (o_data_ready),
        .o_data    (o_pe_payload),
        .o_valid   (o_pe_valid),
        .i_ready   (i_pe_ready)
    );

    assign w_tx_pop  = o_data_valid && i_data_ready;
    assign w_rx_pop  = o_pe_valid && i_pe_ready;
    assign w_rx_drop = i_data_valid && o_data_ready && !w_rx_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_tx_pop && (r_tx_count != '1)) begin
                r_tx_count <= r_tx_count + CntWidth'(1);
            end
            if (w_rx_pop && (r_rx_count != '1)) begin
                r_rx_count <= r_rx_count + CntWidth'(1);
            end
            if (w_rx_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CntWidth'(1);
            end
        end
    end

    assign o_tx_count   = r_tx_count;
    assign o_rx_count   = r_rx_count;
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_noc_endpoint_if.sv
// Directed bench for noc_endpoint_if with MyAddr=0x02 and 4-bit counters so
// saturation is reachable in a short run.
module tb_noc_endpoint_if;

    localparam int DW = 32;
    localparam int PW = 24;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [PW-1:0] pe_payload_in;
    logic [7:0]    pe_dest;
    logic          pe_valid_in;
    logic          pe_ready_out;
    logic [DW-1:0] data_out;
    logic          data_valid_out;
    logic          data_ready_in;
    logic [DW-1:0] data_in;
    logic          data_valid_in;
    logic          data_ready_out;
    logic [PW-1:0] pe_payload_out;
    logic          pe_valid_out;
    logic          pe_ready_in;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_tx   = 0;
    int exp_rx   = 0;
    int exp_drop = 0;
    int rx_idx   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_flits[6];

    typedef struct {
        logic [7:0]    dest;
        logic [PW-1:0] payload;
        logic [DW-1:0] flit;
    } tx_vec_t;

    typedef struct {
        logic [DW-1:0] flit;
        logic          hit;
        logic [PW-1:0] payload;
    } rx_vec_t;

    tx_vec_t tx_vecs[4];
    rx_vec_t rx_vecs[6];

    noc_endpoint_if #(
        .DataWidth (32),
        .MyAddr    (8'h02),
        .TxDepth   (4),
        .RxDepth   (4),
        .CntWidth  (CW)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_pe_payload (pe_payload_in),
        .i_pe_dest    (pe_dest),
        .i_pe_valid   (pe_valid_in),
        .o_pe_ready   (pe_ready_out),
        .o_data       (data_out),
        .o_data_valid (data_valid_out),
        .i_data_ready (data_ready_in),
        .i_data       (data_in),
        .i_data_valid (data_valid_in),
        .o_data_ready (data_ready_out),
        .o_pe_payload (pe_payload_out),
        .o_pe_valid   (pe_valid_out),
        .i_pe_ready   (pe_ready_in),
        .o_tx_count   (tx_count),
        .o_rx_count   (rx_count),
        .o_drop_count (drop_count)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Helpers
    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_tx_count"},   32'(tx_count),   32'(exp_tx));
        check({tag, "_rx_count"},   32'(rx_count),   32'(exp_rx));
        check({tag, "_drop_count"}, 32'(drop_count), 32'(exp_drop));
    endtask

    // One negedge-to-negedge step of the RX stream with scoreboard.
    task automatic rx_step();
        logic acc_in;
        logic acc_out;
        if (rx_idx < 6) begin
            data_in       = rx_flits[rx_idx];
            data_valid_in = 1'b1;
        end else begin
            data_valid_in = 1'b0;
        end
        acc_in  = data_valid_in && data_ready_out;
        acc_out = pe_valid_out && pe_ready_in;
        if (acc_out) begin
            if (exp_q.size() == 0) begin
                check("rx_full_unexpected_payload", 32'(pe_payload_out), 32'hFFFF_FFFF);
            end else begin
                check("rx_full_order", 32'(pe_payload_out), exp_q.pop_front());
                exp_rx = sat(exp_rx + 1);
            end
        end
        next_neg();
        if (acc_in) begin
            exp_q.push_back({8'h00, rx_flits[rx_idx][PW-1:0]});
            rx_idx++;
        end
    endtask

    initial begin
        tx_vecs[0] = '{dest: 8'h02, payload: 24'h000001, flit: 32'h02000001};
        tx_vecs[1] = '{dest: 8'hFF, payload: 24'hFFFFFF, flit: 32'hFFFFFFFF};
        tx_vecs[2] = '{dest: 8'h00, payload: 24'h000000, flit: 32'h00000000};
        tx_vecs[3] = '{dest: 8'hA5, payload: 24'h5A5A5A, flit: 32'hA55A5A5A};

        rx_vecs[0] = '{flit: 32'h02AABBCC, hit: 1'b1, payload: 24'hAABBCC};
        rx_vecs[1] = '{flit: 32'h07DDEEFF, hit: 1'b0, payload: 24'h000000};
        rx_vecs[2] = '{flit: 32'h02000000, hit: 1'b1, payload: 24'h000000};
        rx_vecs[3] = '{flit: 32'h00FFFFFF, hit: 1'b0, payload: 24'h000000};
        rx_vecs[4] = '{flit: 32'h02FFFFFF, hit: 1'b1, payload: 24'hFFFFFF};
        rx_vecs[5] = '{flit: 32'h03123456, hit: 1'b0, payload: 24'h000000};

        for (int k = 0; k < 6; k++) begin
            rx_flits[k] = 32'h02C00000 + k;
        end

        // Reset
        reset_n       = 1'b0;
        pe_payload_in = '0;
        pe_dest       = '0;
        pe_valid_in   = 1'b0;
        data_ready_in = 1'b0;
        data_in       = '0;
        data_valid_in = 1'b0;
        pe_ready_in   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_data_valid", 32'(data_valid_out), 32'd0);
        check("reset_pe_valid",   32'(pe_valid_out),   32'd0);
        check_counters("reset");
        reset_n = 1'b1;
        next_neg();
        check("reset_pe_ready",   32'(pe_ready_out),   32'd1);
        check("reset_data_ready", 32'(data_ready_out), 32'd1);

        // Single TX
        data_ready_in = 1'b1;
        pe_dest       = 8'h05;
        pe_payload_in = 24'h123456;
        pe_valid_in   = 1'b1;
        next_neg();
        pe_valid_in = 1'b0;
        check("single_tx_valid", 32'(data_valid_out), 32'd1);
        check("single_tx_data",  data_out,            32'h05123456);
        next_neg();
        exp_tx = sat(exp_tx + 1);
        check("single_tx_valid_after_pop", 32'(data_valid_out), 32'd0);
        check_counters("single_tx");

        // TX vector table
        for (int i = 0; i < 4; i++) begin
            pe_dest       = tx_vecs[i].dest;
            pe_payload_in = tx_vecs[i].payload;
            pe_valid_in   = 1'b1;
            next_neg();
            pe_valid_in = 1'b0;
            check($sformatf("tx_vec%0d_valid", i), 32'(data_valid_out), 32'd1);
            check($sformatf("tx_vec%0d_data", i),  data_out,            tx_vecs[i].flit);
            next_neg();
            exp_tx = sat(exp_tx + 1);
            check($sformatf("tx_vec%0d_count", i), 32'(tx_count), 32'(exp_tx));
        end

        // RX vector table
        pe_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in       = rx_vecs[i].flit;
            data_valid_in = 1'b1;
            next_neg();
            data_valid_in = 1'b0;
            check($sformatf("rx_vec%0d_valid", i), 32'(pe_valid_out), 32'(rx_vecs[i].hit));
            if (rx_vecs[i].hit) begin
                check($sformatf("rx_vec%0d_payload", i), 32'(pe_payload_out), 32'(rx_vecs[i].payload));
                exp_rx = sat(exp_rx + 1);
            end else begin
                exp_drop = sat(exp_drop + 1);
            end
            next_neg();
            check($sformatf("rx_vec%0d_valid_after", i), 32'(pe_valid_out), 32'd0);
            check_counters($sformatf("rx_vec%0d", i));
        end

        // TX backpressure: 5 attempts into a 4-deep FIFO
        data_ready_in = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            pe_dest       = 8'h10 + 8'(i);
            pe_payload_in = 24'h100000 + 24'(i);
            pe_valid_in   = 1'b1;
            check($sformatf("tx_bp_ready%0d", i), 32'(pe_ready_out), (i < 4) ? 32'd1 : 32'd0);
            next_neg();
            if (i < 4) exp_q.push_back({pe_dest, pe_payload_in});
        end
        pe_valid_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("tx_bp_hold_valid", 32'(data_valid_out), 32'd1);
            check("tx_bp_hold_data",  data_out,            exp_q[0]);
            next_neg();
        end
        data_ready_in = 1'b1;
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
            check("tx_bp_drain_valid", 32'(data_valid_out), 32'd1);
            check("tx_bp_drain_data",  data_out,            exp_q.pop_front());
            next_neg();
            exp_tx = sat(exp_tx + 1);
        end
        check("tx_bp_drain_left", 32'(exp_q.size()), 32'd0);
        check("tx_bp_valid_end",  32'(data_valid_out), 32'd0);
        check_counters("tx_bp");

        // RX full: 6 flits, PE stalled, then released
        pe_ready_in = 1'b0;
        exp_q.delete();
        rx_idx = 0;
        for (int c = 0; c < 8; c++) rx_step();
        check("rx_full_accepted",   32'(rx_idx),         32'd4);
        check("rx_full_data_ready", 32'(data_ready_out), 32'd0);
        check("rx_full_pe_valid",   32'(pe_valid_out),   32'd1);
        check("rx_full_head",       32'(pe_payload_out), 32'h00C00000);
        pe_ready_in = 1'b1;
        for (int c = 0; c < 20 && (rx_idx < 6 || exp_q.size() > 0); c++) rx_step();
        data_valid_in = 1'b0;
        check("rx_full_all_accepted", 32'(rx_idx),       32'd6);
        check("rx_full_all_drained",  32'(exp_q.size()), 32'd0);
        check("rx_full_valid_end",    32'(pe_valid_out), 32'd0);
        check_counters("rx_full");

        // Reset mid-operation with 3 flits queued each way
        data_ready_in = 1'b0;
        pe_ready_in   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pe_dest       = 8'h20;
            pe_payload_in = 24'h300000 + 24'(i);
            pe_valid_in   = 1'b1;
            data_in       = 32'h02400000 + i;
            data_valid_in = 1'b1;
            next_neg();
        end
        pe_valid_in   = 1'b0;
        data_valid_in = 1'b0;
        check("mid_rst_pre_data_valid", 32'(data_valid_out), 32'd1);
        check("mid_rst_pre_pe_valid",   32'(pe_valid_out),   32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        exp_tx   = 0;
        exp_rx   = 0;
        exp_drop = 0;
        check("mid_rst_data_valid", 32'(data_valid_out), 32'd0);
        check("mid_rst_pe_valid",   32'(pe_valid_out),   32'd0);
        check_counters("mid_rst");
        @(negedge clk);
        reset_n       = 1'b1;
        data_ready_in = 1'b1;
        pe_ready_in   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_neg();
            check("post_rst_data_valid", 32'(data_valid_out), 32'd0);
            check("post_rst_pe_valid",   32'(pe_valid_out),   32'd0);
        end
        check_counters("post_rst");

        // Saturation: 20 TX flits and 20 misaddressed RX flits
        for (int i = 0; i < 20; i++) begin
            pe_dest       = 8'h30;
            pe_payload_in = 24'(i);
            pe_valid_in   = 1'b1;
            data_in       = 32'h09000000 + i;
            data_valid_in = 1'b1;
            next_neg();
        end
        pe_valid_in   = 1'b0;
        data_valid_in = 1'b0;
        next_neg();
        exp_tx   = sat(20);
        exp_drop = sat(20);
        check_counters("sat");
        next_neg();
        next_neg();
        check_counters("sat_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
